// File: rtl/tile_sched_pkg.sv
// Shared types for the tile FIFO scheduler: output-slot states, operation select, tile sizing.
// Combinational-only helpers; no state or handshakes live here.
package tile_sched_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_PENDING,
    SLOT_FULL
  } slot_state_e;

  typedef enum logic {
    OP_WRITE,
    OP_READ
  } op_e;

  function automatic int tile_bits(input int width);
    return 16 * width;
  endfunction

endpackage

// File: rtl/tile_sched_ctrl_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr; purely combinational, 0-cycle latency.
// No backpressure of its own: an all-zero req yields an all-zero grant and index 0.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_sched_ctrl.sv
// Round-robin tile FIFO scheduler with tagged output slot (TILE_SCHED_STATS_EN adds grant/stall counters).
// Latency: 2 cycles fifo_read->tile_valid; producers stall while the FIFO is full, slot holds until tile_ready.
module tile_sched_ctrl
  import tile_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 16,
  localparam int TILE_BITS = tile_bits(WIDTH),
  localparam int SW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OW        = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TILE_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_reset,
  output logic                         fifo_write,
  output logic [TILE_BITS-1:0]         fifo_in,
  output logic                         fifo_read,
  input  logic [TILE_BITS-1:0]         fifo_out,
  output logic                         tile_valid,
  output logic [TILE_BITS-1:0]         tile_data,
  output logic [SW-1:0]                tile_src,
  input  logic                         tile_ready,
  output logic [OW-1:0]                occupancy
`ifdef TILE_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        grant_cnt,
  output logic [31:0]                  full_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slot_state_e slot_q, slot_d;
  op_e         prio_q;

  logic [SW-1:0]      rr_ptr_q;
  logic [SW-1:0]      tag_mem [DEPTH];
  logic [PW-1:0]      tag_wr_q, tag_rd_q;
  logic [NUM_REQ-1:0] grant;
  logic [SW-1:0]      win_idx;

  logic write_ok, read_ok, contended, do_write, do_read, accept;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

  assign fifo_reset = ~reset;

  // One FIFO op per cycle; prio only arbitrates when both sides could go.
  always_comb begin
    write_ok  = reset && (|req_valid) && (occupancy < OW'(DEPTH));
    read_ok   = reset && (slot_q == SLOT_EMPTY) && (occupancy != '0);
    contended = write_ok && read_ok;
    do_write  = write_ok && (!read_ok || (prio_q == OP_WRITE));
    do_read   = read_ok && (!write_ok || (prio_q == OP_READ));
  end

  assign req_ready  = do_write ? grant : '0;
  assign fifo_write = do_write;
  assign fifo_read  = do_read;
  assign accept     = tile_valid && tile_ready;

  always_comb begin
    fifo_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) fifo_in = req_data[i*TILE_BITS +: TILE_BITS];
    end
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY:   if (do_read) slot_d = SLOT_PENDING;
      SLOT_PENDING: slot_d = SLOT_FULL;
      SLOT_FULL:    if (accept) slot_d = SLOT_EMPTY;
      default:      slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q     <= SLOT_EMPTY;
      prio_q     <= OP_WRITE;
      rr_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      occupancy  <= '0;
      tile_valid <= 1'b0;
      tile_data  <= '0;
      tile_src   <= '0;
    end else begin
      slot_q <= slot_d;
      if (contended) prio_q <= (prio_q == OP_WRITE) ? OP_READ : OP_WRITE;
      if (do_write) begin
        rr_ptr_q  <= (win_idx == SW'(NUM_REQ - 1)) ? '0 : win_idx + SW'(1);
        tag_wr_q  <= tag_wr_q + PW'(1);
        occupancy <= occupancy + OW'(1);
      end
      // The tag leaves the queue alongside its tile; tile_valid is low until the data lands.
      if (do_read) begin
        tag_rd_q  <= tag_rd_q + PW'(1);
        occupancy <= occupancy - OW'(1);
        tile_src  <= tag_mem[tag_rd_q];
      end
      if (slot_q == SLOT_PENDING) begin
        tile_data  <= fifo_out;
        tile_valid <= 1'b1;
      end else if (accept) begin
        tile_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) tag_mem[tag_wr_q] <= win_idx;
  end

`ifdef TILE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_cnt      <= '0;
      full_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
      if ((|req_valid) && (occupancy == OW'(DEPTH)) && (full_stall_cnt != 32'hFFFF_FFFF))
        full_stall_cnt <= full_stall_cnt + 32'd1;
    end
  end
`endif

  a_occ_bound: assert property (@(posedge clk) disable iff (!reset) occupancy <= OW'(DEPTH));
  a_grant_1h:  assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
  a_one_op:    assert property (@(posedge clk) disable iff (!reset) !(fifo_write && fifo_read));

endmodule

// File: tb/tb_tile_sched_ctrl.sv
// Bench for tile_sched_ctrl: queue-based reference model checked every cycle, plus directed scenarios.
module tb_tile_sched_ctrl;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int TB    = 16 * WIDTH;
  localparam int SW    = 2;
  localparam int OW    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*TB-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_reset, fifo_write, fifo_read;
  logic [TB-1:0]     fifo_in;
  logic [TB-1:0]     fifo_out = '0;
  logic              tile_valid;
  logic [TB-1:0]     tile_data;
  logic [SW-1:0]     tile_src;
  logic              tile_ready;
  logic [OW-1:0]     occupancy;
`ifdef TILE_SCHED_STATS_EN
  logic [N*32-1:0]   grant_cnt;
  logic [31:0]       full_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tile_sched_ctrl #(.NUM_REQ(N), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_reset (fifo_reset),
    .fifo_write (fifo_write),
    .fifo_in    (fifo_in),
    .fifo_read  (fifo_read),
    .fifo_out   (fifo_out),
    .tile_valid (tile_valid),
    .tile_data  (tile_data),
    .tile_src   (tile_src),
    .tile_ready (tile_ready),
    .occupancy  (occupancy)
`ifdef TILE_SCHED_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .full_stall_cnt (full_stall_cnt)
`endif
  );

  task automatic check(input string nm, input logic [TB-1:0] act, input logic [TB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // External tile FIFO: data appears on fifo_out the cycle after fifo_read.
  logic [TB-1:0] ext_q[$];
  always @(posedge clk) begin
    if (fifo_reset) begin
      ext_q.delete();
    end else begin
      if (fifo_write) ext_q.push_back(fifo_in);
      if (fifo_read) begin
        if (ext_q.size() > 0) fifo_out <= ext_q.pop_front();
        else fifo_out <= '1;
      end
    end
  end

  // Reference model: queue of (source, tile) plus the output slot as a pipeline stage count.
  typedef struct {
    int            src;
    logic [TB-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  int            m_occ   = 0;
  int            m_ptr   = 0;
  int            m_stage = 0;
  int            m_src   = 0;
  bit            m_prio_w = 1'b1;
  logic          m_valid = 1'b0;
  logic [TB-1:0] m_data  = '0;
  logic [TB-1:0] m_pend  = '0;
  logic [31:0]   m_gcnt [N];
  logic [31:0]   m_stall = '0;

  int         c_win;
  bit         c_wok, c_rok, c_ew, c_er, c_acc;
  logic [N-1:0] c_rdy;
  ent_t       c_e;

  always @(negedge clk) begin
    c_win = -1;
    for (int k = 0; k < N; k++)
      if (c_win < 0 && req_valid[(m_ptr + k) % N]) c_win = (m_ptr + k) % N;
    c_wok = reset && (c_win >= 0) && (m_occ < DEPTH);
    c_rok = reset && (m_stage == 0) && (m_occ > 0);
    c_ew  = c_wok && (!c_rok || m_prio_w);
    c_er  = c_rok && (!c_wok || !m_prio_w);
    c_rdy = '0;
    if (c_ew) c_rdy[c_win] = 1'b1;

    check("req_ready", req_ready, c_rdy);
    check("fifo_write", fifo_write, c_ew);
    check("fifo_read", fifo_read, c_er);
    check("strobe_excl", fifo_write & fifo_read, 1'b0);
    check("fifo_reset", fifo_reset, !reset);
    if (c_ew) check("fifo_in", fifo_in, req_data[c_win*TB +: TB]);
    check("occupancy", occupancy, m_occ);
    check("tile_valid", tile_valid, m_valid);
    check("tile_data", tile_data, m_data);
    if (m_valid) check("tile_src", tile_src, m_src);
`ifdef TILE_SCHED_STATS_EN
    if (m_occ >= 0) begin
      for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*32 +: 32], m_gcnt[i]);
      check("full_stall_cnt", full_stall_cnt, m_stall);
    end
`endif

    if (!reset) begin
      m_q.delete();
      m_occ = 0; m_ptr = 0; m_stage = 0; m_src = 0; m_prio_w = 1'b1;
      m_valid = 1'b0; m_data = '0;
      for (int i = 0; i < N; i++) m_gcnt[i] = '0;
      m_stall = '0;
    end else begin
      c_acc = m_valid && tile_ready;
      if (c_ew) begin
        c_e.src  = c_win;
        c_e.data = req_data[c_win*TB +: TB];
        m_q.push_back(c_e);
        m_ptr = (c_win + 1) % N;
        m_occ++;
        if (m_gcnt[c_win] != 32'hFFFF_FFFF) m_gcnt[c_win] = m_gcnt[c_win] + 1;
      end
      if (c_win >= 0 && m_occ == DEPTH && !c_ew && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (c_wok && c_rok) m_prio_w = !m_prio_w;
      if (m_stage == 1) begin
        m_stage = 2; m_valid = 1'b1; m_data = m_pend;
      end else if (m_stage == 2 && c_acc) begin
        m_stage = 0; m_valid = 1'b0;
      end
      if (c_er) begin
        c_e = m_q.pop_front();
        m_pend = c_e.data; m_src = c_e.src; m_stage = 1; m_occ--;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0; req_valid = '0; tile_ready = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  function automatic logic [TB-1:0] mk_tile(input logic [15:0] v);
    return {16{v}};
  endfunction

  int g[$];
  int rd_cyc;
  int exp_b[5] = '{0, 1, 2, 3, 0};
  int exp_d[8] = '{1, 1, 2, 1, 1, 1, 2, 1};

  initial begin
    reset = 1'b0; req_valid = 4'hF; tile_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*TB +: TB] = mk_tile(16'h1100 * 16'(i + 1));

    // Reset held with all producers requesting
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_fifo_write", fifo_write, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_tile_valid", tile_valid, 0);
      check("rst_tile_data", tile_data, 0);
      check("rst_tile_src", tile_src, 0);
    end

    // All producers, consumer stalled: fill to DEPTH
    rd_cyc = 0;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      reset = 1'b1; req_valid = 4'hF; tile_ready = 1'b0;
      #1;
      if (fifo_write) for (int i = 0; i < N; i++) if (req_ready[i]) g.push_back(i);
      if (fifo_read) rd_cyc = c;
    end
    check("fill_grant_count", g.size(), 5);
    for (int i = 0; i < 5; i++) if (i < g.size()) check("fill_grant_order", g[i], exp_b[i]);
    check("fill_read_cycle", rd_cyc, 3);
    check("fill_occupancy", occupancy, 4);
    check("fill_req_ready", req_ready, 0);
    check("fill_tile_valid", tile_valid, 1);
    check("fill_tile_src", tile_src, 0);
    check("fill_tile_data", tile_data, mk_tile(16'h1100));
    cyc(); tile_ready = 1'b1; #1;
    check("drain_no_op", {fifo_read, fifo_write}, 0);
    cyc(); tile_ready = 1'b0; #1;
    check("drain_read", fifo_read, 1);
    cyc(); #1;
    check("drain_occupancy", occupancy, 3);
    check("drain_next_grant", req_ready, 4'b0010);
    cyc(); req_valid = '0; tile_ready = 1'b1;
    repeat (20) cyc();

    // Single producer 2, read and output latency
    do_reset();
    cyc();
    req_valid = 4'b0100; tile_ready = 1'b1; req_data[2*TB +: TB] = mk_tile(16'hA5A5);
    #1;
    check("lat_write", fifo_write, 1);
    check("lat_grant", req_ready, 4'b0100);
    cyc(); req_valid = '0; #1;
    check("lat_read", fifo_read, 1);
    check("lat_occ1", occupancy, 1);
    cyc(); #1;
    check("lat_not_yet", tile_valid, 0);
    check("lat_occ0", occupancy, 0);
    cyc(); #1;
    check("lat_valid", tile_valid, 1);
    check("lat_data", tile_data, mk_tile(16'hA5A5));
    check("lat_src", tile_src, 2);

    // Contention alternation trace
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(); req_valid = 4'hF; tile_ready = 1'b1; #1;
      check("ctd_op", {fifo_read, fifo_write}, exp_d[c]);
    end

    // Reset the cycle after fifo_read drops the pending tile
    do_reset();
    cyc(); req_valid = 4'b0001; tile_ready = 1'b0; #1;
    check("mid_write", fifo_write, 1);
    cyc(); req_valid = '0; #1;
    check("mid_read", fifo_read, 1);
    cyc(); reset = 1'b0; #1;
    check("mid_fifo_reset", fifo_reset, 1);
    cyc(); reset = 1'b1; #1;
    check("mid_tile_valid", tile_valid, 0);
    check("mid_occupancy", occupancy, 0);
    cyc(); #1;
    check("mid_no_complete", tile_valid, 0);
    check("mid_no_read", fifo_read, 0);

    // Randomised traffic with occasional resets and varying consumer pressure
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 800; c++) begin
        cyc();
        reset      = ($urandom_range(0, 149) != 0);
        req_valid  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
        tile_ready = ($urandom_range(0, 3) <= seg);
        for (int j = 0; j < N * TB / 32; j++) req_data[j*32 +: 32] = $urandom();
      end
    end

`ifdef TILE_SCHED_STATS_EN
    // Producer 1 alone: 5 accepted tiles then 7 cycles stalled on a full FIFO
    do_reset();
    for (int c = 0; c < 13; c++) begin
      cyc(); req_valid = 4'b0010; tile_ready = 1'b0;
    end
    cyc(); req_valid = '0; #1;
    check("stats_grant1", grant_cnt[32 +: 32], 5);
    check("stats_grant0", grant_cnt[0 +: 32], 0);
    check("stats_stall", full_stall_cnt, 7);
`endif

    cyc(); req_valid = '0; tile_ready = 1'b1;
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
